// File: rtl/lupa_spi_pkg.sv
// Shared constants, power-up register image and FSM state type for the
// LUPA300 3-wire configuration receiver.
package lupa_spi_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 12;
  localparam int FRAME_LEN = ADDR_W + DATA_W;
  localparam int NUM_REGS  = 1 << ADDR_W;

  localparam logic [DATA_W-1:0] LUPA_REG_DEFAULT [NUM_REGS] = '{
    12'h029, 12'h000, 12'h000, 12'h0A0, 12'h002, 12'h000, 12'h000, 12'h1E1,
    12'h04A, 12'h06B, 12'h055, 12'h0F0, 12'hFB0, 12'hADF, 12'h6DB, 12'h0DB
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2,
    OVER  = 2'd3
  } state_e;

endpackage

// File: rtl/spi_reg_bank.sv
// 16x12 configuration register bank: defaults on reset, one write port and
// one registered read port (read-before-write on an address collision).
module spi_reg_bank
  import lupa_spi_pkg::*;
(
  input  logic              clock_20,
  input  logic              reset_p,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic [DATA_W-1:0] r_rd_data;

  // The read samples the array before this cycle's write lands.
  always_ff @(posedge clock_20 or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= LUPA_REG_DEFAULT[i];
      end
      r_rd_data <= LUPA_REG_DEFAULT[0];
    end else begin
      if (i_wr_en) begin
        r_mem[i_wr_addr] <= i_wr_data;
      end
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/spi_reg_receiver.sv
// 3-wire SPI frame receiver: edge detect, 16-bit deserializer, frame-length
// FSM and commit/reject strobes in front of the LUPA300 register bank.
module spi_reg_receiver
  import lupa_spi_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 12
) (
  input  logic              clock_20,
  input  logic              reset_p,
  input  logic              spi_clk,
  input  logic              spi_en,
  input  logic              spi_dat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              err_stb,
  output logic [7:0]        wr_count
);

  localparam int LEN   = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(LEN + 2);

  logic              r_clk_prev;
  logic              r_en_prev;
  state_e            r_state;
  state_e            w_state_nxt;
  logic [LEN-1:0]    r_shreg;
  logic [LEN-1:0]    w_shreg_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_commit;
  logic              w_reject;
  logic              w_clk_rise;
  logic              w_en_rise;
  logic              w_dat;
  logic              r_wr_stb;
  logic              r_err_stb;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [7:0]        r_wr_count;

  assign w_clk_rise = spi_clk & ~r_clk_prev;
  assign w_en_rise  = spi_en & ~r_en_prev;
  // Only a solid 1 counts; a floating or unknown line shifts in 0.
  assign w_dat      = (spi_dat === 1'b1);

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_bit_cnt;
    w_commit    = 1'b0;
    w_reject    = 1'b0;
    if (w_en_rise) begin
      if ((r_state == FULL) && !w_clk_rise) begin
        w_commit = 1'b1;
      end else begin
        w_reject = 1'b1;
      end
      w_state_nxt = IDLE;
      w_shreg_nxt = '0;
      w_cnt_nxt   = '0;
    end else if (w_clk_rise && !spi_en) begin
      case (r_state)
        IDLE: begin
          w_shreg_nxt = {r_shreg[LEN-2:0], w_dat};
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = SHIFT;
        end
        SHIFT: begin
          w_shreg_nxt = {r_shreg[LEN-2:0], w_dat};
          w_cnt_nxt   = r_bit_cnt + CNT_W'(1);
          if (r_bit_cnt == CNT_W'(LEN - 1)) begin
            w_state_nxt = FULL;
          end else begin
            w_state_nxt = SHIFT;
          end
        end
        FULL: begin
          w_shreg_nxt = {r_shreg[LEN-2:0], w_dat};
          w_cnt_nxt   = r_bit_cnt + CNT_W'(1);
          w_state_nxt = OVER;
        end
        OVER: begin
          w_state_nxt = OVER;
        end
        default: begin
          w_state_nxt = IDLE;
          w_shreg_nxt = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  always_ff @(posedge clock_20 or posedge reset_p) begin
    if (reset_p) begin
      r_clk_prev <= 1'b0;
      r_en_prev  <= 1'b0;
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_wr_stb   <= 1'b0;
      r_err_stb  <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_count <= 8'd0;
    end else begin
      r_clk_prev <= spi_clk;
      r_en_prev  <= spi_en;
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bit_cnt  <= w_cnt_nxt;
      r_wr_stb   <= w_commit;
      r_err_stb  <= w_reject;
      if (w_commit) begin
        r_wr_addr  <= r_shreg[LEN-1 -: ADDR_W];
        r_wr_data  <= r_shreg[DATA_W-1:0];
        r_wr_count <= r_wr_count + 8'd1;
      end
    end
  end

  spi_reg_bank u_bank (
    .clock_20  (clock_20),
    .reset_p   (reset_p),
    .i_wr_en   (w_commit),
    .i_wr_addr (r_shreg[LEN-1 -: ADDR_W]),
    .i_wr_data (r_shreg[DATA_W-1:0]),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  assign wr_stb   = r_wr_stb;
  assign err_stb  = r_err_stb;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_spi_reg_receiver.sv
// Self-checking bench: directed frames from the test plan plus randomized
// frames, checked against an array model of the register bank.
module tb_spi_reg_receiver;

  logic        clock_20 = 1'b0;
  logic        reset_p  = 1'b1;
  logic        spi_clk  = 1'b0;
  logic        spi_en   = 1'b0;
  logic        spi_dat  = 1'b0;
  logic [3:0]  rd_addr  = 4'd0;
  logic [11:0] rd_data;
  logic        wr_stb;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic        err_stb;
  logic [7:0]  wr_count;

  int n_chk  = 0;
  int n_pass = 0;
  int n_wr   = 0;
  int n_err  = 0;
  int exp_bank [16];
  int exp_cnt  = 0;
  int def_tab  [16] = '{'h029, 'h000, 'h000, 'h0A0, 'h002, 'h000, 'h000, 'h1E1,
                        'h04A, 'h06B, 'h055, 'h0F0, 'hFB0, 'hADF, 'h6DB, 'h0DB};

  spi_reg_receiver dut (
    .clock_20 (clock_20),
    .reset_p  (reset_p),
    .spi_clk  (spi_clk),
    .spi_en   (spi_en),
    .spi_dat  (spi_dat),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .err_stb  (err_stb),
    .wr_count (wr_count)
  );

  always #25 clock_20 = ~clock_20;

  // Strobe cycles counted away from the active edge.
  always @(negedge clock_20) begin
    if (!reset_p) begin
      if (wr_stb)  n_wr++;
      if (err_stb) n_err++;
    end
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached, required $finish first");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock_20);
  endtask

  task automatic do_reset();
    @(negedge clock_20);
    reset_p = 1'b1; spi_clk = 1'b0; spi_en = 1'b0; spi_dat = 1'b0;
    for (int i = 0; i < 16; i++) exp_bank[i] = def_tab[i];
    exp_cnt = 0;
    idle(2);
    reset_p = 1'b0;
  endtask

  // Master pattern: one low and one high clock_20 cycle per bit, MSB first.
  task automatic send_bits(input logic [15:0] word, input int nbits, input bit collide);
    int idx;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock_20);
      spi_clk = 1'b0;
      idx = 15 - i;
      spi_dat = (i < 16) ? word[idx] : 1'($urandom);
      @(negedge clock_20);
      spi_clk = 1'b1;
      if (collide && (i == nbits - 1)) spi_en = 1'b1;
    end
  endtask

  task automatic run_frame(input int a, input int d, input int nbits, input bit collide);
    bit commit;
    int old_val;
    commit  = (nbits == 16) && !collide;
    old_val = exp_bank[a];
    rd_addr = 4'(a);
    send_bits({4'(a), 12'(d)}, nbits, collide);
    if (!collide) begin
      @(negedge clock_20);
      spi_clk = 1'b0; spi_dat = 1'b0; spi_en = 1'b1;
    end
    @(negedge clock_20);
    check("wr_stb_latency", int'(wr_stb), int'(commit));
    check("err_stb_latency", int'(err_stb), int'(!commit));
    check("rd_collision_old", int'(rd_data), old_val);
    if (commit) begin
      exp_bank[a] = d;
      exp_cnt = (exp_cnt + 1) % 256;
      check("wr_addr", int'(wr_addr), a);
      check("wr_data", int'(wr_data), d);
    end
    spi_clk = 1'b0; spi_en = 1'b0; spi_dat = 1'b0;
  endtask

  task automatic read_chk(input int a);
    @(negedge clock_20);
    rd_addr = 4'(a);
    @(negedge clock_20);
    check($sformatf("rd_data[%0d]", a), int'(rd_data), exp_bank[a]);
  endtask

  task automatic sweep();
    for (int a = 0; a < 16; a++) read_chk(a);
  endtask

  task automatic strobe_deltas(input int wr0, input int err0, input int dwr, input int derr);
    idle(2);
    check("wr_stb_count", n_wr - wr0, dwr);
    check("err_stb_count", n_err - err0, derr);
    check("wr_count", int'(wr_count), exp_cnt);
  endtask

  initial begin
    int wr0, err0, a, d, nb;
    bit col;

    for (int i = 0; i < 16; i++) exp_bank[i] = def_tab[i];
    idle(2);
    check("reset_rd_data", int'(rd_data), 'h029);
    check("reset_wr_stb", int'(wr_stb), 0);
    check("reset_err_stb", int'(err_stb), 0);
    check("reset_wr_addr", int'(wr_addr), 0);
    check("reset_wr_data", int'(wr_data), 0);
    check("reset_wr_count", int'(wr_count), 0);
    reset_p = 1'b0;
    idle(2);
    check("post_reset_no_stb", n_wr + n_err, 0);
    sweep();

    wr0 = n_wr; err0 = n_err;
    run_frame(4, 'h1A5, 16, 1'b0);
    strobe_deltas(wr0, err0, 1, 0);
    sweep();

    wr0 = n_wr; err0 = n_err;
    run_frame(9, 'h777, 15, 1'b0);
    strobe_deltas(wr0, err0, 0, 1);
    run_frame(9, 'h777, 17, 1'b0);
    strobe_deltas(wr0, err0, 0, 2);
    sweep();

    wr0 = n_wr; err0 = n_err;
    run_frame(0, 'h028, 16, 1'b0);
    run_frame(7, 'h3E1, 16, 1'b0);
    run_frame(15, 'h123, 16, 1'b0);
    strobe_deltas(wr0, err0, 3, 0);
    read_chk(0); read_chk(7); read_chk(15);

    wr0 = n_wr; err0 = n_err;
    rd_addr = 4'd2;
    send_bits({4'd2, 12'hABC}, 8, 1'b0);
    do_reset();
    idle(1);
    check("mid_frame_reset_count", int'(wr_count), 0);
    run_frame(2, 'h055, 16, 1'b0);
    strobe_deltas(wr0, err0, 1, 0);
    sweep();

    wr0 = n_wr; err0 = n_err;
    run_frame(5, 'h3C3, 16, 1'b1);
    run_frame(5, 'h5A5, 16, 1'b0);
    strobe_deltas(wr0, err0, 1, 1);
    read_chk(5);

    for (int it = 0; it < 40; it++) begin
      a = int'($urandom_range(0, 15));
      d = int'($urandom_range(0, 4095));
      case ($urandom_range(0, 3))
        0, 1:    nb = 16;
        2:       nb = ($urandom_range(0, 1) == 0) ? 15 : 17;
        default: nb = int'($urandom_range(0, 20));
      endcase
      col = (nb > 0) && ($urandom_range(0, 7) == 0);
      wr0 = n_wr; err0 = n_err;
      run_frame(a, d, nb, col);
      strobe_deltas(wr0, err0, ((nb == 16) && !col) ? 1 : 0, ((nb == 16) && !col) ? 0 : 1);
      read_chk(a);
      read_chk(int'($urandom_range(0, 15)));
    end
    sweep();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_reg_receiver.md
# spi_reg_receiver

Sensor-side receiver for the 3-wire configuration link (spi_clk, spi_en, spi_dat) driven by the FPGA's SPI upload master. It deserializes 4-bit address + 12-bit data frames and commits them to a 16×12 register bank that powers up with the LUPA300 default values. It serves as a register model for loopback and simulation, and it provides readback for upload verification.

## Interface
- `ADDR_W`, default 4: address bits per frame.
- `DATA_W`, default 12: data bits per frame; frame length is `ADDR_W+DATA_W` = 16.
- `clock_20  in  1`: 20 MHz system clock; all logic on posedge.
- `reset_p  in  1`: asynchronous, active-high reset.
- `spi_clk  in  1`: serial clock from master, same clock domain.
- `spi_en  in  1`: load strobe; high after the last bit.
- `spi_dat  in  1`: serial data, MSB first; may be Z outside bit phases.
- `rd_addr  in  4`: readback address.
- `rd_data  out  12`: register content at `rd_addr`, registered.
- `wr_stb  out  1`: one-cycle pulse on every committed write.
- `wr_addr  out  4`: address of the last committed write.
- `wr_data  out  12`: data of the last committed write.
- `err_stb  out  1`: one-cycle pulse on a rejected frame.
- `wr_count  out  8`: number of committed writes; wraps at 255→0.

## Operation
- The master changes its lines on negedge `clock_20`. This block samples them on posedge with no synchronizer.
- Each spi_clk level lasts at least 1 clock_20 cycle.
- One register stage holds previous values of spi_clk and spi_en.
- Rise = current sample 1 and previous sample 0.
- A Z or X on spi_dat is sampled as 0.
- FSM states:
  - IDLE: bit_cnt = 0.
  - SHIFT: 1–15 bits received.
  - FULL: exactly 16 bits received.
  - OVER: more than 16 bits received.
- On an spi_clk rise: `shreg <= {shreg[14:0], spi_dat}`.
  - IDLE→SHIFT.
  - SHIFT→SHIFT; on the 16th bit, →FULL.
  - FULL→OVER.
  - OVER stays OVER with no further shifting.
- On an spi_en rise in FULL, commit the frame:
  - `bank[shreg[15:12]] <= shreg[11:0]`.
  - Update `wr_addr` and `wr_data`, pulse `wr_stb`, increment `wr_count`.
- On an spi_en rise in IDLE, SHIFT or OVER, pulse `err_stb`; the bank is unchanged.
- After any spi_en rise, return to IDLE and clear `bit_cnt` and `shreg`.
- If an spi_clk rise and an spi_en rise are sampled in the same cycle, the frame is rejected: pulse `err_stb`, no write, return to IDLE.
- If spi_en stays high, it has no further effect. spi_clk rises while spi_en is high are ignored.
- Bank defaults (hex, addr 0–F): 029, 000, 000, 0A0, 002, 000, 000, 1E1, 04A, 06B, 055, 0F0, FB0, ADF, 6DB, 0DB.
- Readback is one port, 1-cycle latency. If a read and a write target the same address in the same cycle, `rd_data` returns the old value; the new value appears the next cycle.

## Timing
- Reset values:
  - Bank = defaults; FSM = IDLE; `shreg` = 0.
  - `rd_data` = 0x029, `wr_addr` = 0, `wr_data` = 0, `wr_count` = 0.
  - `wr_stb` = 0, `err_stb` = 0.
- Latency: `wr_stb` asserts 1 cycle after the posedge that samples the spi_en rise. The bank value is readable via `rd_data` 2 cycles after that sample.
- With the master's pattern (1 cycle low, 1 high, 16 bits, then spi_en), one frame is 33 clocks. Back-to-back frames with one idle cycle between them must all commit.
- `reset_p` asserted mid-frame aborts immediately: partial bits are discarded, the bank returns to defaults, and no strobe is generated.
- Strobes are never asserted in the cycle reset deasserts.

## Structure
- Package `lupa_spi_pkg` holds:
  - `ADDR_W`, `DATA_W`, `FRAME_LEN` = 16;
  - the 16-entry default array `LUPA_REG_DEFAULT`;
  - the FSM state enum {IDLE, SHIFT, FULL, OVER}.
- Sub-module `spi_reg_bank`: 16×12 flop array with defaults, one write port, one registered read port. It also has its own `clock_20`/`reset_p`.
- The top level holds edge detect, shift register, bit counter, FSM, strobes and `wr_count`.

## Test plan
- Reset, then read all 16 addresses → each matches the default list (e.g. addr 7 → 0x1E1, addr C → 0xFB0).
- Frame addr 4, data 0x1A5 → one `wr_stb`, `wr_addr` = 4, `wr_data` = 0x1A5, `wr_count` = 1; addr 4 reads 0x1A5, all others still default.
- 15 clocks then spi_en → `err_stb` once, no `wr_stb`, bank unchanged. Repeat with 17 clocks → same result.
- Three back-to-back frames (0→0x028, 7→0x3E1, F→0x123) with one idle cycle between them → 3 `wr_stb`, `wr_count` = 3, all three values read back.
- `reset_p` pulsed after 8 bits of a frame to addr 2, then a full frame addr 2 / 0x055 → only the second frame commits; addr 2 = 0x055, `wr_count` = 1.
- spi_clk rise and spi_en rise sampled in the same cycle → `err_stb`, no write; the next valid frame commits normally.
